// File: rtl/bp_fe_fetch_sequencer.sv
// Front-end fetch sequencer: drives the IF1 request, tracks the IF2 fetch, and replays on miss/drain/redirect.
// Optional performance counters are built when BP_FE_FETCH_SEQ_PERF_EN is defined.
module bp_fe_fetch_sequencer #(
  parameter int vaddr_width_p = 39,
  parameter int fetch_bytes_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  output logic                     fetch_v_o,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  input  logic                     fetch_yumi_i,
  output logic                     if2_v_o,
  output logic [vaddr_width_p-1:0] if2_pc_o,
  input  logic                     if2_hit_v_i,
  input  logic                     if2_miss_v_i,
  input  logic                     if2_yumi_i,
  input  logic                     icache_ready_i,
  output logic                     flush_o
`ifdef BP_FE_FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]              miss_count_o,
  output logic [31:0]              replay_count_o
`endif
);

  localparam logic [1:0] e_wait   = 2'd0;
  localparam logic [1:0] e_run    = 2'd1;
  localparam logic [1:0] e_stall  = 2'd2;
  localparam logic [1:0] e_replay = 2'd3;

  localparam logic [vaddr_width_p-1:0] fetch_mask_lp = vaddr_width_p'(fetch_bytes_p - 1);
  localparam logic [vaddr_width_p-1:0] fetch_incr_lp = vaddr_width_p'(fetch_bytes_p);

  logic [1:0]               r_state;
  logic [vaddr_width_p-1:0] r_pc;
  logic                     r_if2_v;
  logic [vaddr_width_p-1:0] r_if2_pc;

  logic [1:0]               w_state_n;
  logic [vaddr_width_p-1:0] w_pc_n;
  logic                     w_if2_v_n;
  logic [vaddr_width_p-1:0] w_if2_pc_n;
  logic [vaddr_width_p-1:0] w_pc_inc;
  logic                     w_miss;
  logic                     w_drain;
  logic                     w_consume;
  logic                     w_fetch_acc;

  // IF2 results only mean something while a fetch actually occupies IF2.
  assign w_miss      = if2_miss_v_i & r_if2_v;
  assign w_drain     = if2_hit_v_i & r_if2_v & ~if2_yumi_i;
  assign w_consume   = if2_hit_v_i & r_if2_v & if2_yumi_i;
  assign w_fetch_acc = (r_state == e_run) & fetch_yumi_i;
  assign w_pc_inc    = (r_pc & ~fetch_mask_lp) + fetch_incr_lp;

  assign fetch_v_o  = ~reset_i & (r_state == e_run);
  assign fetch_pc_o = r_pc;
  assign if2_v_o    = ~reset_i & r_if2_v;
  assign if2_pc_o   = reset_i ? '0 : r_if2_pc;
  assign flush_o    = ~reset_i & ((redirect_v_i & (r_state != e_wait)) | w_miss | w_drain);

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_if2_v_n  = r_if2_v;
    w_if2_pc_n = r_if2_pc;
    if (redirect_v_i) begin
      w_state_n = e_run;
      w_pc_n    = redirect_pc_i;
      w_if2_v_n = 1'b0;
    end else if (w_miss) begin
      w_state_n = e_stall;
      w_pc_n    = r_if2_pc;
      w_if2_v_n = 1'b0;
    end else if (w_drain) begin
      w_state_n = e_replay;
      w_pc_n    = r_if2_pc;
      w_if2_v_n = 1'b0;
    end else begin
      if (w_fetch_acc) begin
        w_if2_v_n  = 1'b1;
        w_if2_pc_n = r_pc;
        w_pc_n     = w_pc_inc;
      end else if (w_consume) begin
        w_if2_v_n = 1'b0;
      end
      case (r_state)
        e_stall:  if (icache_ready_i) w_state_n = e_run;
        e_replay: w_state_n = e_run;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= e_wait;
      r_pc     <= '0;
      r_if2_v  <= 1'b0;
      r_if2_pc <= '0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_if2_v  <= w_if2_v_n;
      r_if2_pc <= w_if2_pc_n;
    end
  end

`ifdef BP_FE_FETCH_SEQ_PERF_EN
  logic [31:0] r_miss_count;
  logic [31:0] r_replay_count;
  logic        w_enter_stall;
  logic        w_enter_replay;

  assign w_enter_stall  = ~redirect_v_i & w_miss;
  assign w_enter_replay = ~redirect_v_i & ~w_miss & w_drain;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_miss_count   <= '0;
      r_replay_count <= '0;
    end else begin
      if (w_enter_stall && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 32'd1;
      if (w_enter_replay && (r_replay_count != '1))
        r_replay_count <= r_replay_count + 32'd1;
    end
  end

  assign miss_count_o   = r_miss_count;
  assign replay_count_o = r_replay_count;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// Directed bench for bp_fe_fetch_sequencer: reset, run, miss/stall, drain/replay, redirect priority, wrap.
module tb_bp_fe_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_v;
  logic [38:0] redirect_pc;
  logic        fetch_v;
  logic [38:0] fetch_pc;
  logic        fetch_yumi;
  logic        if2_v;
  logic [38:0] if2_pc;
  logic        hit, miss, if2_yumi, ready, flush;
`ifdef BP_FE_FETCH_SEQ_PERF_EN
  logic [31:0] miss_count, replay_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_fe_fetch_sequencer #(.vaddr_width_p(39), .fetch_bytes_p(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .redirect_v_i   (redirect_v),
    .redirect_pc_i  (redirect_pc),
    .fetch_v_o      (fetch_v),
    .fetch_pc_o     (fetch_pc),
    .fetch_yumi_i   (fetch_yumi),
    .if2_v_o        (if2_v),
    .if2_pc_o       (if2_pc),
    .if2_hit_v_i    (hit),
    .if2_miss_v_i   (miss),
    .if2_yumi_i     (if2_yumi),
    .icache_ready_i (ready),
    .flush_o        (flush)
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    ,
    .miss_count_o   (miss_count),
    .replay_count_o (replay_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs set afterwards apply to the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect_v = 1'b0; redirect_pc = '0; fetch_yumi = 1'b0;
    hit = 1'b0; miss = 1'b0; if2_yumi = 1'b0; ready = 1'b0;

    // Reset state, including a redirect that must be ignored while reset is high
    cyc();
    redirect_v = 1'b1; redirect_pc = 39'h123; #1;
    check("rst_fetch_v", fetch_v, 0);
    check("rst_if2_v", if2_v, 0);
    check("rst_flush", flush, 0);
    check("rst_if2_pc", if2_pc, 0);
    cyc();
    redirect_v = 1'b0;
    cyc();
    check("rst_fetch_pc", fetch_pc, 0);
    reset = 1'b0;
    cyc();
    check("wait_fetch_v", fetch_v, 0);

    // Redirect out of e_wait, then one accepted fetch
    redirect_v = 1'b1; redirect_pc = 39'h8000_0002; #1;
    check("wait_redirect_flush", flush, 0);
    cyc();
    redirect_v = 1'b0;
    check("run_fetch_v", fetch_v, 1);
    check("run_fetch_pc", fetch_pc, 39'h8000_0002);
    check("run_if2_v_empty", if2_v, 0);
    fetch_yumi = 1'b1;
    cyc();
    check("yumi_if2_v", if2_v, 1);
    check("yumi_if2_pc", if2_pc, 39'h8000_0002);
    check("yumi_fetch_pc", fetch_pc, 39'h8000_0004);

    // Hit consumed with a new fetch accepted in the same cycle keeps IF2 loaded
    hit = 1'b1; if2_yumi = 1'b1; fetch_yumi = 1'b1; #1;
    check("hit_consume_flush", flush, 0);
    cyc();
    fetch_yumi = 1'b0;
    check("pipe_if2_v", if2_v, 1);
    check("pipe_if2_pc", if2_pc, 39'h8000_0004);
    check("pipe_fetch_pc", fetch_pc, 39'h8000_0008);
    cyc();
    hit = 1'b0; if2_yumi = 1'b0;
    check("consume_if2_clear", if2_v, 0);
    check("consume_fetch_pc", fetch_pc, 39'h8000_0008);

    // Miss at 0x1000, icache_ready_i arriving in the miss cycle itself
    redirect_v = 1'b1; redirect_pc = 39'h1000; #1;
    check("run_redirect_flush", flush, 1);
    cyc();
    redirect_v = 1'b0;
    check("redir_fetch_pc", fetch_pc, 39'h1000);
    fetch_yumi = 1'b1;
    cyc();
    check("miss_setup_if2_pc", if2_pc, 39'h1000);
    miss = 1'b1; ready = 1'b1; #1;
    check("miss_flush", flush, 1);
    cyc();
    miss = 1'b0; ready = 1'b0; fetch_yumi = 1'b0;
    check("stall_fetch_v", fetch_v, 0);
    check("stall_if2_v", if2_v, 0);
    check("stall_fetch_pc", fetch_pc, 39'h1000);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("miss_count_1", miss_count, 1);
`endif
    cyc();
    check("stall_hold_fetch_v", fetch_v, 0);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    check("refetch_fetch_v", fetch_v, 1);
    check("refetch_pc", fetch_pc, 39'h1000);

    // Drain at 0x2004: one idle cycle, then refetch 0x2004
    redirect_v = 1'b1; redirect_pc = 39'h2004;
    cyc();
    redirect_v = 1'b0; fetch_yumi = 1'b1;
    cyc();
    fetch_yumi = 1'b0;
    check("drain_setup_if2_pc", if2_pc, 39'h2004);
    check("drain_setup_fetch_pc", fetch_pc, 39'h2008);
    hit = 1'b1; if2_yumi = 1'b0; #1;
    check("drain_flush", flush, 1);
    cyc();
    hit = 1'b0;
    check("replay_fetch_v", fetch_v, 0);
    check("replay_if2_v", if2_v, 0);
    check("replay_fetch_pc", fetch_pc, 39'h2004);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("replay_count_1", replay_count, 1);
`endif
    cyc();
    check("post_replay_fetch_v", fetch_v, 1);
    check("post_replay_fetch_pc", fetch_pc, 39'h2004);

    // Redirect wins over a same-cycle miss
    fetch_yumi = 1'b1;
    cyc();
    fetch_yumi = 1'b0;
    check("prio_setup_if2_v", if2_v, 1);
    miss = 1'b1; redirect_v = 1'b1; redirect_pc = 39'h3000; #1;
    check("prio_flush", flush, 1);
    cyc();
    miss = 1'b0; redirect_v = 1'b0;
    check("prio_fetch_v", fetch_v, 1);
    check("prio_fetch_pc", fetch_pc, 39'h3000);
    check("prio_if2_v", if2_v, 0);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("prio_miss_count", miss_count, 1);
`endif

    // PC wraps at the top of the address space
    redirect_v = 1'b1; redirect_pc = 39'h7F_FFFF_FFFC;
    cyc();
    redirect_v = 1'b0;
    check("wrap_pre_pc", fetch_pc, 39'h7F_FFFF_FFFC);
    fetch_yumi = 1'b1;
    cyc();
    fetch_yumi = 1'b0;
    check("wrap_fetch_pc", fetch_pc, 0);
    check("wrap_if2_pc", if2_pc, 39'h7F_FFFF_FFFC);

    // Reset during e_stall discards state; icache_ready_i ignored until redirect
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    check("rst_stall_pre_fetch_v", fetch_v, 0);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("miss_count_2", miss_count, 2);
`endif
    reset = 1'b1;
    cyc();
    check("rst_stall_fetch_v", fetch_v, 0);
    check("rst_stall_fetch_pc", fetch_pc, 0);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("rst_miss_count", miss_count, 0);
    check("rst_replay_count", replay_count, 0);
`endif
    reset = 1'b0; ready = 1'b1;
    cyc();
    check("rst_ready_ignored_1", fetch_v, 0);
    cyc();
    check("rst_ready_ignored_2", fetch_v, 0);
    ready = 1'b0;
    redirect_v = 1'b1; redirect_pc = 39'h4000;
    cyc();
    redirect_v = 1'b0;
    check("rst_redirect_fetch_v", fetch_v, 1);
    check("rst_redirect_fetch_pc", fetch_pc, 39'h4000);

    // Redirect out of e_stall flushes and restarts at the new target
    fetch_yumi = 1'b1;
    cyc();
    fetch_yumi = 1'b0; miss = 1'b1;
    cyc();
    miss = 1'b0;
    check("stall2_fetch_v", fetch_v, 0);
    redirect_v = 1'b1; redirect_pc = 39'h5000; #1;
    check("stall_redirect_flush", flush, 1);
    cyc();
    redirect_v = 1'b0;
    check("stall_redirect_fetch_v", fetch_v, 1);
    check("stall_redirect_fetch_pc", fetch_pc, 39'h5000);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    check("miss_count_after_rst", miss_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
